// File: rtl/jump_redirect_ctrl_if.sv
// Front-end control-transfer bundle between the ID/EX pipeline and the jump redirect controller.
interface jump_redirect_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_opcode;
    logic        stall_in;
    logic        ex_target_valid;
    logic [1:0]  pc_sel;
    logic        pc_hold;
    logic        flush_ifid;
    logic        issue_jr;
    logic        link_req;
    logic        busy;
    logic        timeout_err;
    logic [15:0] jump_count;

    modport master (
        output id_valid, id_opcode, stall_in, ex_target_valid,
        input  pc_sel, pc_hold, flush_ifid, issue_jr, link_req,
        input  busy, timeout_err, jump_count
    );

    modport slave (
        input  id_valid, id_opcode, stall_in, ex_target_valid,
        output pc_sel, pc_hold, flush_ifid, issue_jr, link_req,
        output busy, timeout_err, jump_count
    );
endinterface

// File: rtl/jump_redirect_ctrl.sv
// Sequences J/JAL/JR/JALR redirects: PC source select, fetch hold, IF/ID squash,
// R7 link request, saturating redirect count and sticky JR/JALR timeout flag.
module jump_redirect_ctrl #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jump_redirect_ctrl_if.slave    jr_if
);

    localparam logic [4:0] LP_OP_J    = 5'b00100;
    localparam logic [4:0] LP_OP_JR   = 5'b00101;
    localparam logic [4:0] LP_OP_JAL  = 5'b00110;
    localparam logic [4:0] LP_OP_JALR = 5'b00111;
    localparam logic [7:0] LP_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_RUN,
        S_WAIT_EX
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_jump_count;
    logic        r_timeout_err;

    logic w_accept;
    logic w_op_imm;
    logic w_op_reg;
    logic w_wait_more;
    logic w_inc;

    assign w_op_imm    = (jr_if.id_opcode == LP_OP_J)  || (jr_if.id_opcode == LP_OP_JAL);
    assign w_op_reg    = (jr_if.id_opcode == LP_OP_JR) || (jr_if.id_opcode == LP_OP_JALR);
    assign w_accept    = (r_state == S_RUN) && jr_if.id_valid && !jr_if.stall_in;
    assign w_wait_more = (r_wait_cnt < LP_LAST);
    assign w_inc       = (w_accept && w_op_imm) ||
                         ((r_state == S_WAIT_EX) && jr_if.ex_target_valid);

    always_comb begin
        jr_if.pc_sel     = 2'b00;
        jr_if.pc_hold    = 1'b0;
        jr_if.flush_ifid = 1'b0;
        jr_if.issue_jr   = 1'b0;
        jr_if.link_req   = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (w_accept && w_op_imm) begin
                    jr_if.pc_sel     = 2'b01;
                    jr_if.flush_ifid = 1'b1;
                    jr_if.link_req   = (jr_if.id_opcode == LP_OP_JAL);
                end else if (w_accept && w_op_reg) begin
                    jr_if.issue_jr   = 1'b1;
                    jr_if.pc_hold    = 1'b1;
                    jr_if.flush_ifid = 1'b1;
                    jr_if.link_req   = (jr_if.id_opcode == LP_OP_JALR);
                end
            end
            S_WAIT_EX: begin
                jr_if.flush_ifid = 1'b1;
                if (jr_if.ex_target_valid) begin
                    jr_if.pc_sel = 2'b10;
                end else if (w_wait_more) begin
                    jr_if.pc_hold = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_jump_count  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (w_accept && w_op_reg) begin
                        r_state    <= S_WAIT_EX;
                        r_wait_cnt <= '0;
                    end
                end
                S_WAIT_EX: begin
                    if (jr_if.ex_target_valid) begin
                        r_state <= S_RUN;
                    end else if (w_wait_more) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end else begin
                        // Abandon the wait; fetch resumes sequentially and the error stays latched.
                        r_state       <= S_RUN;
                        r_timeout_err <= 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
            if (w_inc && (r_jump_count != '1)) begin
                r_jump_count <= r_jump_count + 16'd1;
            end
        end
    end

    assign jr_if.busy        = (r_state == S_WAIT_EX);
    assign jr_if.timeout_err = r_timeout_err;
    assign jr_if.jump_count  = r_jump_count;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Self-checking bench for jump_redirect_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the redirect rules.
module tb_jump_redirect_ctrl;

    localparam int TO = 4;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    jump_redirect_ctrl_if bus ();

    jump_redirect_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .jr_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] op, input logic s, input logic ex);
        bus.id_valid        = v;
        bus.id_opcode       = op;
        bus.stall_in        = s;
        bus.ex_target_valid = ex;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.pc_sel !== 2'b00) begin n_errors++; $display("FAIL reset_pc_sel: got %b exp 00", bus.pc_sel); end
            n_checks++; if (bus.pc_hold !== 1'b0) begin n_errors++; $display("FAIL reset_pc_hold: got %b exp 0", bus.pc_hold); end
            n_checks++; if (bus.flush_ifid !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %b exp 0", bus.flush_ifid); end
            n_checks++; if (bus.jump_count !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", bus.jump_count); end
            n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
            n_checks++; if (bus.timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b exp 0", bus.timeout_err); end
        end
    endtask

    task automatic test_j_jal();
        @(negedge clk); drive(1'b1, OP_J, 1'b0, 1'b0); #1;
        n_checks++; if (bus.pc_sel !== 2'b01) begin n_errors++; $display("FAIL j_pc_sel: got %b exp 01", bus.pc_sel); end
        n_checks++; if (bus.flush_ifid !== 1'b1) begin n_errors++; $display("FAIL j_flush: got %b exp 1", bus.flush_ifid); end
        n_checks++; if (bus.link_req !== 1'b0) begin n_errors++; $display("FAIL j_link: got %b exp 0", bus.link_req); end
        n_checks++; if (bus.pc_hold !== 1'b0) begin n_errors++; $display("FAIL j_hold: got %b exp 0", bus.pc_hold); end
        @(negedge clk); drive(1'b1, OP_JAL, 1'b0, 1'b0); #1;
        n_checks++; if (bus.jump_count !== 16'd1) begin n_errors++; $display("FAIL j_count: got %0d exp 1", bus.jump_count); end
        n_checks++; if (bus.link_req !== 1'b1) begin n_errors++; $display("FAIL jal_link: got %b exp 1", bus.link_req); end
        n_checks++; if (bus.pc_sel !== 2'b01) begin n_errors++; $display("FAIL jal_pc_sel: got %b exp 01", bus.pc_sel); end
        @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (bus.jump_count !== 16'd2) begin n_errors++; $display("FAIL jal_count: got %0d exp 2", bus.jump_count); end
        n_checks++; if (bus.flush_ifid !== 1'b0) begin n_errors++; $display("FAIL jal_idle_flush: got %b exp 0", bus.flush_ifid); end
    endtask

    task automatic test_jalr();
        @(negedge clk); drive(1'b1, OP_JALR, 1'b0, 1'b0); #1;
        n_checks++; if (bus.issue_jr !== 1'b1) begin n_errors++; $display("FAIL jalr_issue: got %b exp 1", bus.issue_jr); end
        n_checks++; if (bus.link_req !== 1'b1) begin n_errors++; $display("FAIL jalr_link: got %b exp 1", bus.link_req); end
        n_checks++; if (bus.pc_hold !== 1'b1) begin n_errors++; $display("FAIL jalr_hold: got %b exp 1", bus.pc_hold); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL jalr_issue_busy: got %b exp 0", bus.busy); end
        @(negedge clk); drive(1'b1, OP_J, 1'b0, 1'b0); #1;
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL jalr_wait_busy: got %b exp 1", bus.busy); end
        n_checks++; if (bus.pc_hold !== 1'b1) begin n_errors++; $display("FAIL jalr_wait_hold: got %b exp 1", bus.pc_hold); end
        n_checks++; if (bus.pc_sel !== 2'b00) begin n_errors++; $display("FAIL jalr_wait_sel: got %b exp 00", bus.pc_sel); end
        @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b1); #1;
        n_checks++; if (bus.pc_sel !== 2'b10) begin n_errors++; $display("FAIL jalr_res_sel: got %b exp 10", bus.pc_sel); end
        n_checks++; if (bus.pc_hold !== 1'b0) begin n_errors++; $display("FAIL jalr_res_hold: got %b exp 0", bus.pc_hold); end
        @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL jalr_run_busy: got %b exp 0", bus.busy); end
        n_checks++; if (bus.jump_count !== 16'd3) begin n_errors++; $display("FAIL jalr_count: got %0d exp 3", bus.jump_count); end
    endtask

    task automatic test_stall();
        int issues;
        issues = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1'b1, OP_JR, 1'b1, 1'b0); #1;
            n_checks++; if (bus.issue_jr !== 1'b0) begin n_errors++; $display("FAIL stall_issue: got %b exp 0", bus.issue_jr); end
            n_checks++; if (bus.flush_ifid !== 1'b0) begin n_errors++; $display("FAIL stall_flush: got %b exp 0", bus.flush_ifid); end
        end
        @(negedge clk); drive(1'b1, OP_JR, 1'b0, 1'b0); #1;
        if (bus.issue_jr === 1'b1) issues++;
        @(negedge clk); drive(1'b1, OP_JR, 1'b0, 1'b0); #1;
        if (bus.issue_jr === 1'b1) issues++;
        @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b1); #1;
        if (bus.issue_jr === 1'b1) issues++;
        n_checks++; if (issues != 1) begin n_errors++; $display("FAIL stall_issue_once: got %0d exp 1", issues); end
        @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (bus.jump_count !== 16'd4) begin n_errors++; $display("FAIL stall_count: got %0d exp 4", bus.jump_count); end
    endtask

    task automatic test_timeout();
        @(negedge clk); drive(1'b1, OP_JR, 1'b0, 1'b0); #1;
        n_checks++; if (bus.issue_jr !== 1'b1) begin n_errors++; $display("FAIL to_issue: got %b exp 1", bus.issue_jr); end
        for (int i = 0; i < TO; i++) begin
            @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b0); #1;
            n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL to_busy[%0d]: got %b exp 1", i, bus.busy); end
            n_checks++; if (bus.pc_hold !== (i < TO - 1)) begin n_errors++; $display("FAIL to_hold[%0d]: got %b exp %b", i, bus.pc_hold, (i < TO - 1)); end
            n_checks++; if (bus.pc_sel !== 2'b00) begin n_errors++; $display("FAIL to_sel[%0d]: got %b exp 00", i, bus.pc_sel); end
            n_checks++; if (bus.timeout_err !== 1'b0) begin n_errors++; $display("FAIL to_err_early[%0d]: got %b exp 0", i, bus.timeout_err); end
        end
        @(negedge clk); drive(1'b1, OP_J, 1'b0, 1'b0); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL to_run_busy: got %b exp 0", bus.busy); end
        n_checks++; if (bus.timeout_err !== 1'b1) begin n_errors++; $display("FAIL to_err: got %b exp 1", bus.timeout_err); end
        n_checks++; if (bus.jump_count !== 16'd4) begin n_errors++; $display("FAIL to_count: got %0d exp 4", bus.jump_count); end
        @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b1); #1;
        n_checks++; if (bus.timeout_err !== 1'b1) begin n_errors++; $display("FAIL to_err_sticky: got %b exp 1", bus.timeout_err); end
        n_checks++; if (bus.jump_count !== 16'd5) begin n_errors++; $display("FAIL to_count_after: got %0d exp 5", bus.jump_count); end
        n_checks++; if (bus.pc_sel !== 2'b00) begin n_errors++; $display("FAIL to_ex_ignored: got %b exp 00", bus.pc_sel); end
    endtask

    task automatic test_random();
        bit   waiting;
        int   waited;
        int   m_count;
        bit   m_err;
        logic v, s, ex;
        logic [4:0] op;
        logic [1:0] e_sel;
        logic e_hold, e_flush, e_issue, e_link, e_busy;
        apply_reset();
        waiting = 0; waited = 0; m_count = 0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 3) == 0);
            ex = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
                0: op = OP_J;
                1: op = OP_JR;
                2: op = OP_JAL;
                3: op = OP_JALR;
                default: op = 5'($urandom);
            endcase
            @(negedge clk); drive(v, op, s, ex); #1;
            e_sel = 2'b00; e_hold = 0; e_flush = 0; e_issue = 0; e_link = 0; e_busy = waiting;
            n_checks++; if (bus.jump_count !== 16'(m_count)) begin n_errors++; $display("FAIL rnd_count@%0d: got %0d exp %0d", c, bus.jump_count, m_count); end
            n_checks++; if (bus.timeout_err !== m_err) begin n_errors++; $display("FAIL rnd_err@%0d: got %b exp %b", c, bus.timeout_err, m_err); end
            if (!waiting) begin
                if (v && !s && (op == OP_J || op == OP_JAL)) begin
                    e_sel = 2'b01; e_flush = 1; e_link = (op == OP_JAL);
                    if (m_count < 65535) m_count++;
                end else if (v && !s && (op == OP_JR || op == OP_JALR)) begin
                    e_issue = 1; e_hold = 1; e_flush = 1; e_link = (op == OP_JALR);
                    waiting = 1; waited = 0;
                end
            end else begin
                e_flush = 1;
                waited++;
                if (ex) begin
                    e_sel = 2'b10; waiting = 0;
                    if (m_count < 65535) m_count++;
                end else if (waited < TO) begin
                    e_hold = 1;
                end else begin
                    m_err = 1; waiting = 0;
                end
            end
            n_checks++; if (bus.pc_sel !== e_sel) begin n_errors++; $display("FAIL rnd_sel@%0d: got %b exp %b", c, bus.pc_sel, e_sel); end
            n_checks++; if (bus.pc_hold !== e_hold) begin n_errors++; $display("FAIL rnd_hold@%0d: got %b exp %b", c, bus.pc_hold, e_hold); end
            n_checks++; if (bus.flush_ifid !== e_flush) begin n_errors++; $display("FAIL rnd_flush@%0d: got %b exp %b", c, bus.flush_ifid, e_flush); end
            n_checks++; if (bus.issue_jr !== e_issue) begin n_errors++; $display("FAIL rnd_issue@%0d: got %b exp %b", c, bus.issue_jr, e_issue); end
            n_checks++; if (bus.link_req !== e_link) begin n_errors++; $display("FAIL rnd_link@%0d: got %b exp %b", c, bus.link_req, e_link); end
            n_checks++; if (bus.busy !== e_busy) begin n_errors++; $display("FAIL rnd_busy@%0d: got %b exp %b", c, bus.busy, e_busy); end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        @(negedge clk); drive(1'b1, OP_J, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (bus.jump_count !== 16'hFFFE) begin n_errors++; $display("FAIL sat_preload: got %h exp fffe", bus.jump_count); end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (bus.jump_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold: got %h exp ffff", bus.jump_count); end
        n_checks++; if (bus.pc_sel !== 2'b01) begin n_errors++; $display("FAIL sat_redirect: got %b exp 01", bus.pc_sel); end
        drive(1'b1, OP_JR, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL arst_pre_busy: got %b exp 1", bus.busy); end
        n_checks++; if (bus.jump_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_after_jr: got %h exp ffff", bus.jump_count); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL arst_busy: got %b exp 0", bus.busy); end
        n_checks++; if (bus.jump_count !== 16'd0) begin n_errors++; $display("FAIL arst_count: got %h exp 0", bus.jump_count); end
        n_checks++; if (bus.flush_ifid !== 1'b0) begin n_errors++; $display("FAIL arst_flush: got %b exp 0", bus.flush_ifid); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_j_jal();
        test_jalr();
        test_stall();
        test_timeout();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jump_redirect_ctrl.md
# jump_redirect_ctrl

Sequencing controller for control-transfer instructions in the fetch/decode front end of the 16-bit pipelined core. It watches the opcode in the ID stage and drives PC source selection, PC hold and IF/ID squash:
- J/JAL redirect immediately from the ID-computed target.
- JR/JALR hold fetch until EX delivers the register-based target.

It also issues the R7 link-write request, keeps a saturating redirect counter, and flags a stuck JR/JALR resolution.

## Interface
Parameters:
- TIMEOUT, default 8: maximum number of cycles spent in WAIT_EX before abandoning the wait (legal range 1–255).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- id_valid  in  1  ID stage holds a real (non-bubble) instruction.
- id_opcode  in  5  opcode field of the ID instruction.
- stall_in  in  1  data-hazard stall from the hazard unit; the ID instruction is held this cycle.
- ex_target_valid  in  1  EX stage has computed the JR/JALR target this cycle.
- pc_sel  out  2  next-PC source: 00 = PC+2, 01 = ID target, 10 = EX target; 11 is never driven.
- pc_hold  out  1  freeze the PC and IF/ID.
- flush_ifid  out  1  replace IF/ID with a bubble on the next edge.
- issue_jr  out  1  JR/JALR is leaving ID for EX this cycle.
- link_req  out  1  the issuing instruction writes PC+2 to R7 (JAL, JALR).
- busy  out  1  FSM is in WAIT_EX.
- timeout_err  out  1  sticky; set when a WAIT_EX timeout occurs.
- jump_count  out  16  saturating count of completed redirects.

## Operation
Opcodes:
- J = 00100
- JR = 00101
- JAL = 00110
- JALR = 00111
- All other opcodes are non-jumps.

"Accept" means `id_valid & !stall_in` in RUN.

The FSM has two states, RUN and WAIT_EX. Reset state is RUN.

**RUN**
- Default outputs: pc_sel=00; pc_hold, flush_ifid, issue_jr and link_req all 0.
- Accept J or JAL:
  - pc_sel=01, flush_ifid=1.
  - link_req=1 for JAL only.
  - jump_count increments.
  - Stay in RUN.
- Accept JR or JALR:
  - issue_jr=1, pc_hold=1, flush_ifid=1.
  - link_req=1 for JALR only.
  - Next state WAIT_EX; the wait counter loads 0.
- No accept (including stall_in=1 with a jump opcode in ID): default outputs, no state change.
- ex_target_valid is ignored in RUN.

**WAIT_EX**
- busy=1 and flush_ifid=1; id_valid and stall_in are ignored.
- ex_target_valid=1:
  - pc_sel=10, pc_hold=0.
  - jump_count increments.
  - Next state RUN.
- Otherwise, while the wait counter is below TIMEOUT-1:
  - pc_hold=1, pc_sel=00.
  - The counter increments.
- Timeout (counter = TIMEOUT-1 and ex_target_valid=0):
  - pc_hold=0, pc_sel=00.
  - timeout_err is set.
  - No count increment.
  - Next state RUN.

Arithmetic:
- jump_count saturates at 16'hFFFF; an increment at saturation leaves it unchanged.
- The wait counter is 8 bits.

## Timing
- All outputs except jump_count, busy and timeout_err are combinational (Mealy) from state and same-cycle inputs.
- State, the wait counter, jump_count and timeout_err update on the rising clk edge.
- Values on reset:
  - state = RUN, wait counter = 0, jump_count = 0, timeout_err = 0.
  - Resulting outputs: busy=0, and all Mealy outputs at RUN defaults when id_valid=0.
- Reset is asynchronous: asserting rst_n low mid-WAIT_EX returns the FSM to RUN immediately, with no redirect and no count.
- Latency:
  - J/JAL redirect is taken in the same cycle as acceptance, costing one squashed fetch.
  - JR/JALR costs 1 + N cycles, where N is the number of WAIT_EX cycles until ex_target_valid. Minimum N is 1.
- With ex_target_valid=1 on the first WAIT_EX cycle, the redirect occurs on the cycle after issue_jr.
- A jump opcode with stall_in=1 produces no outputs until the cycle stall_in drops. Only then is it accepted, and it is accepted exactly once.
- Back-to-back jumps: after J/JAL, ID holds a bubble, so the next accept is at least two cycles later. The controller places no extra restriction.

## Test plan
- Reset, then id_valid=0 for 3 cycles: pc_sel=00, pc_hold=0, flush_ifid=0, jump_count=0, busy=0.
- J accepted: same cycle pc_sel=01, flush_ifid=1, link_req=0; jump_count becomes 1. JAL next: link_req=1; count becomes 2.
- JALR accepted, ex_target_valid raised 2 cycles later:
  - Issue cycle: issue_jr=1, link_req=1, pc_hold=1.
  - Next cycle: busy=1, pc_hold=1.
  - Resolution cycle: pc_sel=10, pc_hold=0.
  - Following cycle: state RUN, count incremented.
- JR held with stall_in=1 for 3 cycles: no issue_jr during the stall; issue_jr pulses exactly once after release.
- JR with ex_target_valid never asserted, TIMEOUT=4: busy for 4 cycles, then timeout_err=1 and RUN; count unchanged; timeout_err remains 1 until rst_n.
- Preload jump_count to 16'hFFFE via 65534 J accepts, then 2 more: count stays 16'hFFFF. rst_n low in WAIT_EX: busy=0 and count=0 without waiting for a clock edge.
